// File: rtl/nubus_pkg.sv
// Shared types for the NuBus CPU request queue: error-bit indices, FSM states
// and the request FIFO entry layout.
package nubus_pkg;

  typedef enum int {
    ERR_TIMEOUT   = 0,
    ERR_MEM       = 1,
    ERR_TRY_AGAIN = 2,
    ERR_PARITY    = 3
  } err_bit_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BACKOFF,
    S_RESP
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  write;
    logic        lock;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/nubus_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through output. A push while full is
// dropped even if a pop happens in the same cycle.
module nubus_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: storage is not reset; pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/nubus_cpu_queue.sv
// Buffers processor requests and issues them one at a time to the NuBus controller,
// re-issuing on try-again. Define NUBUS_POSTED_WRITE_EN for posted (response-less) writes.
module nubus_cpu_queue
  import nubus_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 3,
  parameter int BACKOFF   = 2
) (
  input  logic        nub_clk,
  input  logic        nub_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_write,
  input  logic        req_lock,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [3:0]  rsp_error,
  output logic        cpu_valid,
  output logic [31:0] cpu_addr,
  output logic [31:0] cpu_wdata,
  output logic [3:0]  cpu_write,
  output logic        cpu_lock,
  input  logic        cpu_ready,
  input  logic [31:0] cpu_rdata,
  input  logic [3:0]  cpu_errors,
  output logic        cpu_eclr,
  output logic [3:0]  wr_err_sticky,
  output logic        busy
);

  localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int BW      = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;
  localparam int BO_INIT = (BACKOFF > 0) ? BACKOFF - 1 : 0;
  localparam logic [RW-1:0] RETRY_LIMIT = MAX_RETRY[RW-1:0];
  localparam logic [BW-1:0] BO_LOAD     = BO_INIT[BW-1:0];

  state_t        state;
  state_t        state_next;
  fifo_entry_t   req_entry;
  fifo_entry_t   head;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [RW-1:0] retry_cnt;
  logic [BW-1:0] bo_cnt;
  logic          done;
  logic          retry;
  logic          retire;
  logic          is_write;
  logic          need_rsp;

  // Ready is forced low while reset is held so nothing is accepted into a flushing queue.
  assign req_ready = !fifo_full && !nub_reset;
  assign fifo_push = req_valid && req_ready;
  assign req_entry = '{addr: req_addr, wdata: req_wdata, write: req_write, lock: req_lock};

  nubus_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (nub_clk),
    .reset (nub_reset),
    .push  (fifo_push),
    .din   (req_entry),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign is_write = (cpu_write != '0);
  assign done     = (state == S_ISSUE) && cpu_ready;
  assign retry    = done && cpu_errors[ERR_TRY_AGAIN] && (retry_cnt < RETRY_LIMIT);
  assign retire   = done && !retry;
  assign fifo_pop = retire;

`ifdef NUBUS_POSTED_WRITE_EN
  assign need_rsp = !is_write;

  always_ff @(posedge nub_clk) begin
    if (nub_reset)               wr_err_sticky <= '0;
    else if (retire && is_write) wr_err_sticky <= wr_err_sticky | cpu_errors;
  end
`else
  assign need_rsp      = 1'b1;
  assign wr_err_sticky = '0;
`endif

  always_ff @(posedge nub_clk) begin
    if (nub_reset) state <= S_IDLE;
    else           state <= state_next;
  end

  // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (!fifo_empty) state_next = S_ISSUE;
      S_ISSUE: begin
        if (retry)         state_next = (BACKOFF > 0) ? S_BACKOFF : S_ISSUE;
        else if (retire)   state_next = need_rsp ? S_RESP : S_IDLE;
      end
      S_BACKOFF: if (bo_cnt == '0) state_next = S_ISSUE;
      S_RESP:    if (rsp_ready) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_valid = (state == S_ISSUE);
    rsp_valid = (state == S_RESP);
    busy      = !fifo_empty || (state != S_IDLE);
  end

  // The head entry is captured once per request; retries re-issue from these registers.
  always_ff @(posedge nub_clk) begin
    if (nub_reset) begin
      cpu_addr  <= '0;
      cpu_wdata <= '0;
      cpu_write <= '0;
      cpu_lock  <= 1'b0;
      cpu_eclr  <= 1'b0;
      retry_cnt <= '0;
      bo_cnt    <= '0;
      rsp_rdata <= '0;
      rsp_error <= '0;
    end else begin
      if (state == S_IDLE && !fifo_empty) begin
        cpu_addr  <= head.addr;
        cpu_wdata <= head.wdata;
        cpu_write <= head.write;
        cpu_lock  <= head.lock;
      end
      cpu_eclr <= retry || (retire && (cpu_errors != '0));
      if (retry)       retry_cnt <= retry_cnt + 1'b1;
      else if (retire) retry_cnt <= '0;
      if (retry)                   bo_cnt <= BO_LOAD;
      else if (state == S_BACKOFF) bo_cnt <= bo_cnt - 1'b1;
      if (retire) begin
        rsp_rdata <= is_write ? '0 : cpu_rdata;
        rsp_error <= cpu_errors;
      end
    end
  end

endmodule

// File: tb/tb_nubus_cpu_queue.sv
// Directed self-checking bench for nubus_cpu_queue (default parameters); expectations
// follow NUBUS_POSTED_WRITE_EN when the bench is built with it.
module tb_nubus_cpu_queue;

  logic        nub_clk    = 1'b0;
  logic        nub_reset  = 1'b1;
  logic        req_valid  = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr   = '0;
  logic [31:0] req_wdata  = '0;
  logic [3:0]  req_write  = '0;
  logic        req_lock   = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready  = 1'b0;
  logic [31:0] rsp_rdata;
  logic [3:0]  rsp_error;
  logic        cpu_valid;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_write;
  logic        cpu_lock;
  logic        cpu_ready  = 1'b0;
  logic [31:0] cpu_rdata  = '0;
  logic [3:0]  cpu_errors = '0;
  logic        cpu_eclr;
  logic [3:0]  wr_err_sticky;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  int eclr_cnt  = 0;
  int issue_cnt = 0;
  int rsp_cnt   = 0;
  int low_run   = 0;
  bit prev_valid = 1'b0;
  int gaps [16];

  nubus_cpu_queue dut (
    .nub_clk       (nub_clk),
    .nub_reset     (nub_reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_write     (req_write),
    .req_lock      (req_lock),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_error     (rsp_error),
    .cpu_valid     (cpu_valid),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_write     (cpu_write),
    .cpu_lock      (cpu_lock),
    .cpu_ready     (cpu_ready),
    .cpu_rdata     (cpu_rdata),
    .cpu_errors    (cpu_errors),
    .cpu_eclr      (cpu_eclr),
    .wr_err_sticky (wr_err_sticky),
    .busy          (busy)
  );

  always #5 nub_clk = ~nub_clk;

  // Counts eclr cycles, cpu_valid rises (with the idle gap before each) and response handshakes.
  always @(negedge nub_clk) begin
    if (cpu_eclr) eclr_cnt++;
    if (cpu_valid && !prev_valid) begin
      gaps[issue_cnt % 16] = low_run;
      issue_cnt++;
    end
    low_run    = cpu_valid ? 0 : low_run + 1;
    prev_valid = cpu_valid;
    if (rsp_valid && rsp_ready) rsp_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge nub_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w, input logic l);
    req_addr  = a;
    req_wdata = d;
    req_write = w;
    req_lock  = l;
    req_valid = 1'b1;
    tick(1);
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!cpu_valid && n < 50) begin
      tick(1);
      n++;
    end
    check(tag, cpu_valid, 1'b1);
  endtask

  task automatic finish_xfer(input logic [31:0] rdata, input logic [3:0] err);
    cpu_rdata  = rdata;
    cpu_errors = err;
    cpu_ready  = 1'b1;
    tick(1);
    cpu_ready  = 1'b0;
    cpu_errors = '0;
  endtask

  initial begin
    int b_eclr, b_issue, b_rsp;

    // Reset state
    tick(2);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_cpu_valid", cpu_valid, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_eclr", cpu_eclr, 1'b0);
    check("rst_cpu_addr", cpu_addr, 32'h0);
    check("rst_sticky", wr_err_sticky, 4'h0);
    nub_reset = 1'b0;
    tick(1);
    check("post_rst_req_ready", req_ready, 1'b1);

    // Single locked read, controller ready after three cycles
    b_eclr = eclr_cnt; b_rsp = rsp_cnt;
    push(32'hF900_0000, 32'h0, 4'h0, 1'b1);
    check("rd_valid_not_yet", cpu_valid, 1'b0);
    tick(1);
    check("rd_valid_k1", cpu_valid, 1'b1);
    check("rd_addr", cpu_addr, 32'hF900_0000);
    check("rd_write", cpu_write, 4'h0);
    check("rd_lock", cpu_lock, 1'b1);
    check("rd_busy", busy, 1'b1);
    tick(2);
    check("rd_addr_hold", cpu_addr, 32'hF900_0000);
    check("rd_valid_hold", cpu_valid, 1'b1);
    finish_xfer(32'h1234_5678, 4'h0);
    check("rd_valid_clr", cpu_valid, 1'b0);
    check("rd_rsp_valid", rsp_valid, 1'b1);
    check("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
    check("rd_rsp_error", rsp_error, 4'h0);
    tick(1);
    check("rd_rsp_hold", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    check("rd_rsp_done", rsp_valid, 1'b0);
    check("rd_idle_busy", busy, 1'b0);
    check("rd_rsp_count", rsp_cnt - b_rsp, 1);
    check("rd_no_eclr", eclr_cnt - b_eclr, 0);

    // Five back-to-back writes with the controller stalled, then push-while-full against a pop
    b_issue = issue_cnt; b_rsp = rsp_cnt;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_addr  = 32'h1000_0000 + 32'(i * 4);
      req_wdata = 32'hA000_0000 | 32'(i);
      req_write = 4'hF;
      req_lock  = 1'b0;
      req_valid = 1'b1;
      check("fill_req_ready", req_ready, (i < 4) ? 1'b1 : 1'b0);
      tick(1);
    end
    check("full_req_ready", req_ready, 1'b0);
    check("full_cpu_valid", cpu_valid, 1'b1);
    check("full_cpu_addr", cpu_addr, 32'h1000_0000);
    check("full_cpu_wdata", cpu_wdata, 32'hA000_0000);
    check("full_cpu_write", cpu_write, 4'hF);
    tick(2);
    check("stall_cpu_addr", cpu_addr, 32'h1000_0000);
    check("stall_req_ready", req_ready, 1'b0);
    finish_xfer(32'h0, 4'h0);
    check("pop_push_refused", req_ready, 1'b1);
    req_valid = 1'b0;
    for (int j = 1; j < 4; j++) begin
      wait_valid("drain_valid");
      check("drain_addr", cpu_addr, 32'h1000_0000 + 32'(j * 4));
      finish_xfer(32'h0, 4'h0);
    end
    tick(4);
    check("drain_busy", busy, 1'b0);
    check("drain_issues", issue_cnt - b_issue, 4);
`ifdef NUBUS_POSTED_WRITE_EN
    check("drain_rsp_count", rsp_cnt - b_rsp, 0);
`else
    check("drain_rsp_count", rsp_cnt - b_rsp, 4);
`endif
    rsp_ready = 1'b0;

    // Try-again on every completion: three retries, then exhaustion
    b_eclr = eclr_cnt; b_issue = issue_cnt;
    push(32'h2000_0040, 32'h0, 4'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_valid("retry_valid");
      check("retry_addr", cpu_addr, 32'h2000_0040);
      finish_xfer(32'hDEAD_BEEF, 4'h4);
    end
    check("retry_rsp_valid", rsp_valid, 1'b1);
    check("retry_rsp_error", rsp_error, 4'h4);
    check("retry_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    tick(1);
    check("retry_issues", issue_cnt - b_issue, 4);
    check("retry_eclr", eclr_cnt - b_eclr, 4);
    for (int k = 1; k < 4; k++) check("retry_gap", gaps[(b_issue + k) % 16], 2);
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    check("retry_idle", busy, 1'b0);

    // Write completing with a timeout error
    b_eclr = eclr_cnt;
    push(32'h3000_0000, 32'h0000_0055, 4'h3, 1'b0);
    wait_valid("werr_valid");
    finish_xfer(32'hAAAA_5555, 4'h1);
    check("werr_eclr", cpu_eclr, 1'b1);
`ifdef NUBUS_POSTED_WRITE_EN
    check("werr_no_rsp", rsp_valid, 1'b0);
    check("werr_sticky", wr_err_sticky, 4'h1);
`else
    check("werr_rsp_valid", rsp_valid, 1'b1);
    check("werr_rsp_error", rsp_error, 4'h1);
    check("werr_rsp_rdata", rsp_rdata, 32'h0);
    check("werr_sticky", wr_err_sticky, 4'h0);
`endif
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    tick(1);
    check("werr_eclr_count", eclr_cnt - b_eclr, 1);

    // Reset in the middle of a transfer with further entries queued
    push(32'h4000_0000, 32'h0, 4'h0, 1'b0);
    push(32'h4000_0004, 32'h0, 4'h0, 1'b0);
    push(32'h4000_0008, 32'h0, 4'h0, 1'b0);
    check("mid_valid", cpu_valid, 1'b1);
    b_issue = issue_cnt; b_rsp = rsp_cnt;
    nub_reset = 1'b1;
    tick(1);
    check("mid_rst_valid", cpu_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_req_ready", req_ready, 1'b0);
    check("mid_rst_sticky", wr_err_sticky, 4'h0);
    nub_reset = 1'b0;
    tick(1);
    check("mid_post_req_ready", req_ready, 1'b1);
    check("mid_post_busy", busy, 1'b0);
    cpu_ready = 1'b1;
    rsp_ready = 1'b1;
    tick(8);
    cpu_ready = 1'b0;
    rsp_ready = 1'b0;
    check("mid_no_issue", issue_cnt - b_issue, 0);
    check("mid_no_rsp", rsp_cnt - b_rsp, 0);
    check("mid_valid_low", cpu_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nubus_cpu_queue.md
NUBUS_CPU_QUEUE -- requirements
Module: nubus_cpu_queue

Interface
REQ-001 Parameter DEPTH, default 4: request FIFO entries; power of two, at least 2.
REQ-002 Parameter MAX_RETRY, default 3: retries per request on a try-again error.
REQ-003 Parameter BACKOFF, default 2: idle cycles between a try-again and the re-issue.
REQ-004 The block SHALL use one clock (nub_clk) and a synchronous, active-high reset (nub_reset).
REQ-005 nub_clk in 1: clock, all state on rising edge.
REQ-006 nub_reset in 1: synchronous active-high reset.
REQ-007 req_valid in 1 / req_ready out 1: processor request handshake.
REQ-008 req_addr in 32, req_wdata in 32, req_write in 4, req_lock in 1: address, write data, byte enables (0 = read), locked transfer.
REQ-009 rsp_valid out 1 / rsp_ready in 1: response handshake.
REQ-010 rsp_rdata out 32, rsp_error out 4: read data and error code.
REQ-011 cpu_valid out 1, cpu_addr out 32, cpu_wdata out 32, cpu_write out 4, cpu_lock out 1: request to the NuBus controller.
REQ-012 cpu_ready in 1, cpu_rdata in 32, cpu_errors in 4: completion from the controller.
REQ-013 cpu_eclr out 1: one-cycle error-clear pulse to the controller.
REQ-014 wr_err_sticky out 4, busy out 1: accumulated posted-write errors; high while the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-015 req_ready SHALL equal ~full; a push while full is refused even if a pop occurs in the same cycle.
REQ-016 Push and pop in the same cycle on a non-full FIFO SHALL leave the count unchanged; pointers wrap modulo DEPTH.
REQ-017 Requests SHALL issue strictly in FIFO order, one outstanding at a time.
REQ-018 FSM states: IDLE, ISSUE, BACKOFF, RESP.
REQ-019 IDLE to ISSUE when the FIFO is non-empty: latch the head into the cpu_* registers and set cpu_valid. A request accepted at edge k SHALL have cpu_valid high from edge k+1.
REQ-020 In ISSUE, cpu_valid and the cpu_* outputs SHALL hold stable until cpu_ready is sampled high; cpu_valid clears on that edge.
REQ-021 On completion with cpu_errors[2] (try-again) set and retry_cnt < MAX_RETRY: increment retry_cnt, pulse cpu_eclr, go to BACKOFF. No pop.
REQ-022 BACKOFF SHALL last exactly BACKOFF cycles, then go to ISSUE with the same entry.
REQ-023 Any other completion SHALL pop the entry and clear retry_cnt. If cpu_errors != 0, pulse cpu_eclr.
REQ-024 Completion needing a response: go to RESP with rsp_rdata = cpu_rdata (0 for writes) and rsp_error = cpu_errors. Otherwise go to IDLE.
REQ-025 RESP SHALL hold rsp_valid and its data until rsp_ready, then go to IDLE.
REQ-026 Retry exhaustion SHALL complete normally with cpu_errors[2] reported.
REQ-027 Error bits: [0] timeout, [1] memory error, [2] try-again, [3] parity.

Reset
REQ-028 On nub_reset: FIFO flushed, state IDLE, retry_cnt 0, and all outputs 0 (req_ready included); req_ready becomes 1 on the first cycle after reset deasserts.
REQ-029 Reset mid-transfer SHALL drop cpu_valid at that edge and discard the in-flight request and any pending response.

Configuration
REQ-030 With NUBUS_POSTED_WRITE_EN defined: writes produce no response; nonzero write errors OR into wr_err_sticky (cleared only by reset).
REQ-031 Without NUBUS_POSTED_WRITE_EN: every write produces a response; wr_err_sticky is tied to 0.

Structure
REQ-032 Package nubus_pkg SHALL hold the error-bit index constants, the FSM state enum and the FIFO entry struct {addr, wdata, write, lock}.
REQ-033 The FIFO SHALL be the sub-module nubus_sync_fifo (DEPTH, WIDTH parameters; push/pop/full/empty).

Verification
REQ-034 Read addr 0xF9000000, cpu_ready after 3 cycles with rdata 0x12345678 -> one rsp, rdata 0x12345678, error 0.
REQ-035 DEPTH=4, 5 back-to-back writes, cpu_ready held low -> req_ready low after 4 accepts; cpu_* unchanged until ready.
REQ-036 Try-again on 4 consecutive completions, MAX_RETRY=3 -> 4 issues, 2-cycle gaps, 3 eclr pulses plus a final one, rsp_error=0x4.
REQ-037 Macro on, write completes with error 0x1 -> no rsp, wr_err_sticky=0x1. Macro off -> rsp_error=0x1.
REQ-038 Reset asserted with cpu_valid high and 2 queued -> cpu_valid 0 next edge, busy 0, no rsp afterwards.
REQ-039 Push when full at the same edge as a pop -> push refused, count goes 4 to 3.
